spi_port_arbiter: RTL and testbench

Shares the single `spi_read_byte` SPI read engine between two requesters: the CPU instruction-fetch port and a data-load port. It arbitrates using fixed fetch priority with a starvation guard for the data port, and sequences each engine transaction. It also enforces a completion timeout so a stuck external RAM cannot hang the CPU. The block sits between the fetch/execute FSM (plus data-load logic) and the SPI engine, inside the SPI CPU top level.

---
 rtl/spi_port_arbiter_if.sv | 39 +++
 rtl/spi_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_spi_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_port_arbiter_if.sv
// Bundle of the two requester ports and the SPI read-engine handshake.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface spi_port_arbiter_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        f_rvalid;
    logic [7:0]  f_rdata;
    logic        f_err;

    logic        d_req;
    logic [15:0] d_addr;
    logic        d_ack;
    logic        d_rvalid;
    logic [7:0]  d_rdata;
    logic        d_err;

    logic        eng_start;
    logic [15:0] eng_addr;
    logic        eng_busy;
    logic        eng_done;
    logic [7:0]  eng_data;

    logic        arb_busy;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, eng_busy, eng_done, eng_data,
        output f_ack, f_rvalid, f_rdata, f_err,
        output d_ack, d_rvalid, d_rdata, d_err,
        output eng_start, eng_addr, arb_busy
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, eng_busy, eng_done, eng_data,
        input  f_ack, f_rvalid, f_rdata, f_err,
        input  d_ack, d_rvalid, d_rdata, d_err,
        input  eng_start, eng_addr, arb_busy
    );
endinterface

// File: rtl/spi_port_arbiter.sv
// Shares one SPI read engine between the fetch and data-load ports: fetch priority
// with a starvation guard for data, and a completion timeout with post-timeout drain.
module spi_port_arbiter #(
    parameter int MAX_FETCH_STREAK = 4,
    parameter int TIMEOUT          = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_port_arbiter_if.slave    bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_FETCH_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [SW-1:0]   streak_r;
    logic [SW-1:0]   streak_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_s;
    logic            owner_r;     // 1'b0 = fetch, 1'b1 = data
    logic            owner_s;

    logic            grant_s;
    logic            pick_data_s;
    logic            done_s;
    logic            tmo_s;

    logic            f_ack_r, f_rvalid_r, f_err_r;
    logic            d_ack_r, d_rvalid_r, d_err_r;
    logic [7:0]      f_rdata_r, d_rdata_r;
    logic            eng_start_r, arb_busy_r;
    logic [15:0]     eng_addr_r;

    logic            f_ack_s, f_rvalid_s, f_err_s;
    logic            d_ack_s, d_rvalid_s, d_err_s;
    logic [7:0]      f_rdata_s, d_rdata_s, resp_data_s;
    logic            eng_start_s, arb_busy_s;
    logic [15:0]     eng_addr_s;

    // Arbitration and completion events; requests only matter while IDLE
    always_comb begin
        grant_s     = 1'b0;
        pick_data_s = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_s     = (bus.f_req | bus.d_req) & ~bus.eng_busy;
            pick_data_s = bus.d_req &
                          (~bus.f_req | (streak_r == SW'(MAX_FETCH_STREAK)));
        end else if (state_r == ST_WAIT) begin
            // A completion in the timeout cycle counts as a normal completion
            done_s = bus.eng_done;
            tmo_s  = ~bus.eng_done & (timer_r == TW'(TIMEOUT - 1));
        end else begin
            grant_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_next_s = ST_WAIT;
                else         state_next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (done_s)     state_next_s = ST_IDLE;
                else if (tmo_s) state_next_s = ST_DRAIN;
                else            state_next_s = ST_WAIT;
            end
            ST_DRAIN: begin
                if (!bus.eng_busy) state_next_s = ST_IDLE;
                else               state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        f_ack_s     = grant_s & ~pick_data_s;
        d_ack_s     = grant_s &  pick_data_s;
        eng_start_s = grant_s;
        eng_addr_s  = eng_addr_r;
        if (grant_s) begin
            eng_addr_s = pick_data_s ? bus.d_addr : bus.f_addr;
        end else begin
            eng_addr_s = eng_addr_r;
        end

        resp_data_s = done_s ? bus.eng_data : 8'hFF;
        f_rvalid_s  = (done_s | tmo_s) & ~owner_r;
        d_rvalid_s  = (done_s | tmo_s) &  owner_r;
        f_err_s     = f_rvalid_s & tmo_s;
        d_err_s     = d_rvalid_s & tmo_s;
        f_rdata_s   = f_rvalid_s ? resp_data_s : f_rdata_r;
        d_rdata_s   = d_rvalid_s ? resp_data_s : d_rdata_r;
        arb_busy_s  = (state_next_s != ST_IDLE);

        streak_s = streak_r;
        owner_s  = owner_r;
        if (grant_s) begin
            owner_s = pick_data_s;
            if (pick_data_s || !bus.d_req) begin
                streak_s = SW'(0);
            end else if (streak_r != SW'(MAX_FETCH_STREAK)) begin
                streak_s = streak_r + SW'(1);
            end else begin
                streak_s = streak_r;
            end
        end else begin
            owner_s = owner_r;
        end

        if (grant_s) begin
            timer_s = TW'(0);
        end else if (state_r == ST_WAIT) begin
            timer_s = timer_r + TW'(1);
        end else begin
            timer_s = timer_r;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_ack_r     <= 1'b0;
            f_rvalid_r  <= 1'b0;
            f_rdata_r   <= 8'h00;
            f_err_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= 8'h00;
            d_err_r     <= 1'b0;
            eng_start_r <= 1'b0;
            eng_addr_r  <= 16'h0000;
            arb_busy_r  <= 1'b0;
            streak_r    <= SW'(0);
            timer_r     <= TW'(0);
            owner_r     <= 1'b0;
        end else begin
            f_ack_r     <= f_ack_s;
            f_rvalid_r  <= f_rvalid_s;
            f_rdata_r   <= f_rdata_s;
            f_err_r     <= f_err_s;
            d_ack_r     <= d_ack_s;
            d_rvalid_r  <= d_rvalid_s;
            d_rdata_r   <= d_rdata_s;
            d_err_r     <= d_err_s;
            eng_start_r <= eng_start_s;
            eng_addr_r  <= eng_addr_s;
            arb_busy_r  <= arb_busy_s;
            streak_r    <= streak_s;
            timer_r     <= timer_s;
            owner_r     <= owner_s;
        end
    end

    assign bus.f_ack     = f_ack_r;
    assign bus.f_rvalid  = f_rvalid_r;
    assign bus.f_rdata   = f_rdata_r;
    assign bus.f_err     = f_err_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_err     = d_err_r;
    assign bus.eng_start = eng_start_r;
    assign bus.eng_addr  = eng_addr_r;
    assign bus.arb_busy  = arb_busy_r;

endmodule

// File: tb/tb_spi_port_arbiter.sv
// Directed bench for spi_port_arbiter: a transaction-level model stamped by cycle
// number is compared to the DUT every cycle, plus hand-computed literal checks.
module tb_spi_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_port_arbiter_if bus ();

    spi_port_arbiter #(.MAX_FETCH_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Engine: either an automatic responder or manual control from the main sequence
    logic       eng_auto = 1'b1;
    logic       a_busy = 1'b0, a_done = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       m_busy = 1'b0, m_done = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         eng_lat = 5;
    logic [7:0] eng_resp = 8'h00;
    int         e_cnt = 0;

    assign bus.eng_busy = eng_auto ? a_busy : m_busy;
    assign bus.eng_done = eng_auto ? a_done : m_done;
    assign bus.eng_data = eng_auto ? a_data : m_data;

    initial begin
        forever begin
            @(negedge clk);
            a_done = 1'b0;
            if (e_cnt > 0) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    a_done = 1'b1;
                    a_data = eng_resp;
                    a_busy = 1'b0;
                end
            end else if (eng_auto && bus.eng_start) begin
                a_busy = 1'b1;
                e_cnt  = eng_lat;
            end
        end
    end

    // Checking infrastructure
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: transactions tracked by start cycle and phase
    int         cyc = 0;
    int         m_phase = 0;       // 0 idle, 1 outstanding, 2 draining
    int         m_start = 0;
    int         m_streak = 0;
    bit         m_owner_d = 1'b0;
    logic       e_f_ack = 1'b0, e_f_rvalid = 1'b0, e_f_err = 1'b0;
    logic       e_d_ack = 1'b0, e_d_rvalid = 1'b0, e_d_err = 1'b0;
    logic [7:0] e_f_rdata = 8'h00, e_d_rdata = 8'h00;
    logic       e_eng_start = 1'b0, e_arb_busy = 1'b0;
    logic [15:0] e_eng_addr = 16'h0000;

    task automatic deliver(input logic [7:0] dat, input logic err);
        if (m_owner_d) begin
            e_d_rvalid = 1'b1; e_d_rdata = dat; e_d_err = err;
        end else begin
            e_f_rvalid = 1'b1; e_f_rdata = dat; e_f_err = err;
        end
    endtask

    task automatic model_step();
        bit dw;
        cyc++;
        e_f_ack = 1'b0; e_d_ack = 1'b0; e_eng_start = 1'b0;
        e_f_rvalid = 1'b0; e_d_rvalid = 1'b0; e_f_err = 1'b0; e_d_err = 1'b0;
        if (!rst_n) begin
            m_phase = 0; m_streak = 0; m_owner_d = 1'b0;
            e_eng_addr = 16'h0000; e_f_rdata = 8'h00; e_d_rdata = 8'h00;
        end else if (m_phase == 0) begin
            if ((bus.f_req || bus.d_req) && !bus.eng_busy) begin
                dw = bus.d_req && (!bus.f_req || m_streak == MAXS);
                if (dw || !bus.d_req) m_streak = 0;
                else if (m_streak < MAXS) m_streak = m_streak + 1;
                m_owner_d   = dw;
                e_eng_addr  = dw ? bus.d_addr : bus.f_addr;
                e_eng_start = 1'b1;
                if (dw) e_d_ack = 1'b1; else e_f_ack = 1'b1;
                m_start = cyc;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.eng_done) begin
                deliver(bus.eng_data, 1'b0);
                m_phase = 0;
            end else if (cyc - m_start == TMO) begin
                deliver(8'hFF, 1'b1);   // error response lands TIMEOUT cycles after start
                m_phase = 2;
            end
        end else begin
            if (!bus.eng_busy) m_phase = 0;
        end
        e_arb_busy = (m_phase != 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("f_ack",     bus.f_ack,     e_f_ack);
                chk("f_rvalid",  bus.f_rvalid,  e_f_rvalid);
                chk("f_rdata",   bus.f_rdata,   e_f_rdata);
                chk("f_err",     bus.f_err,     e_f_err);
                chk("d_ack",     bus.d_ack,     e_d_ack);
                chk("d_rvalid",  bus.d_rvalid,  e_d_rvalid);
                chk("d_rdata",   bus.d_rdata,   e_d_rdata);
                chk("d_err",     bus.d_err,     e_d_err);
                chk("eng_start", bus.eng_start, e_eng_start);
                chk("eng_addr",  bus.eng_addr,  e_eng_addr);
                chk("arb_busy",  bus.arb_busy,  e_arb_busy);
            end
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: sig = bus.f_ack;
            1: sig = bus.d_ack;
            2: sig = bus.f_rvalid;
            3: sig = bus.d_rvalid;
            4: sig = ~bus.arb_busy;
            5: sig = bus.f_ack | bus.d_ack;
            default: sig = 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int sel, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < maxc);
        chk(nm, sig(sel), 1'b1);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  n;
    int  starts;
    int  seen;
    string gseq;

    initial begin
        rst_n = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = 16'h0000;
        bus.d_req = 1'b0; bus.d_addr = 16'h0000;
        tick(2);
        chk_en = 1'b1;
        chk("reset_arb_busy", bus.arb_busy, 1'b0);
        chk("reset_eng_addr", bus.eng_addr, 16'h0000);
        rst_n = 1'b1;
        tick(2);

        // Single fetch
        eng_lat = 40; eng_resp = 8'hA5;
        bus.f_req = 1'b1; bus.f_addr = 16'h0012;
        wait_sig("t1_wait_ack", 0, 10, n);
        chk("t1_grant_latency", n, 1);
        chk("t1_eng_start", bus.eng_start, 1'b1);
        chk("t1_eng_addr", bus.eng_addr, 16'h0012);
        bus.f_req = 1'b0;
        wait_sig("t1_wait_rvalid", 2, 100, n);
        chk("t1_rdata", bus.f_rdata, 8'hA5);
        chk("t1_err", bus.f_err, 1'b0);
        chk("t1_d_rvalid", bus.d_rvalid, 1'b0);
        tick(2);

        // Simultaneous requests: fetch first, then data
        eng_lat = 5; eng_resp = 8'h3E;
        bus.f_req = 1'b1; bus.f_addr = 16'h0004;
        bus.d_req = 1'b1; bus.d_addr = 16'h0800;
        wait_sig("t2_wait_fack", 5, 10, n);
        chk("t2_first_is_fetch", bus.f_ack, 1'b1);
        chk("t2_first_addr", bus.eng_addr, 16'h0004);
        bus.f_req = 1'b0;
        wait_sig("t2_wait_dack", 1, 50, n);
        chk("t2_data_addr", bus.eng_addr, 16'h0800);
        bus.d_req = 1'b0;
        wait_sig("t2_wait_drvalid", 3, 50, n);
        chk("t2_d_rdata", bus.d_rdata, 8'h3E);

        // Starvation guard: both held high
        eng_lat = 3;
        bus.f_req = 1'b1; bus.d_req = 1'b1;
        gseq = "";
        for (int g = 0; g < 6; g++) begin
            wait_sig("t3_wait_grant", 5, 50, n);
            gseq = {gseq, bus.d_ack ? "D" : "F"};
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        n_chk++;
        if (gseq != "FFFFDF") begin
            n_fail++;
            $display("FAIL t3_grant_order: got %s expected FFFFDF", gseq);
        end
        wait_sig("t3_idle", 4, 50, n);

        // Timeout and drain
        eng_auto = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        tick(1);
        bus.d_req = 1'b1; bus.d_addr = 16'h0300;
        wait_sig("t4_wait_dack", 1, 5, n);
        m_busy = 1'b1; bus.d_req = 1'b0;
        n = 0; starts = 0;
        while (!bus.d_rvalid && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.eng_start) starts++;
        end
        chk("t4_timeout_cycles", n, TMO);
        chk("t4_d_err", bus.d_err, 1'b1);
        chk("t4_d_rdata", bus.d_rdata, 8'hFF);
        bus.f_req = 1'b1; bus.f_addr = 16'h0040;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.eng_start || bus.f_ack) starts++;
        end
        m_done = 1'b1; m_data = 8'h33;
        tick(1);
        m_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.d_rvalid || bus.f_rvalid) seen++;
        end
        chk("t4_no_start_while_busy", starts, 0);
        chk("t4_late_done_dropped", seen, 0);
        chk("t4_still_busy", bus.arb_busy, 1'b1);
        eng_resp = 8'h5C;
        m_busy = 1'b0; eng_auto = 1'b1;
        wait_sig("t4_wait_fack", 0, 10, n);
        chk("t4_grant_addr", bus.eng_addr, 16'h0040);
        bus.f_req = 1'b0;
        wait_sig("t4_wait_frvalid", 2, 50, n);
        chk("t4_f_rdata", bus.f_rdata, 8'h5C);

        // Busy gating after reset
        tick(1);
        eng_auto = 1'b0; m_busy = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = 16'h0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t5_no_ack_busy", bus.f_ack, 1'b0);
            chk("t5_no_start_busy", bus.eng_start, 1'b0);
        end
        eng_resp = 8'h81;
        m_busy = 1'b0; eng_auto = 1'b1;
        tick(1);
        chk("t5_ack_after_busy", bus.f_ack, 1'b1);
        chk("t5_addr", bus.eng_addr, 16'h0100);
        bus.f_req = 1'b0;
        wait_sig("t5_wait_rvalid", 2, 50, n);
        chk("t5_rdata", bus.f_rdata, 8'h81);

        // Reset in the middle of an outstanding transaction
        tick(1);
        eng_auto = 1'b0; m_busy = 1'b0;
        bus.f_req = 1'b1; bus.f_addr = 16'h0200;
        wait_sig("t6_wait_ack", 0, 5, n);
        bus.f_req = 1'b0; m_busy = 1'b1;
        tick(10);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_arb_busy", bus.arb_busy, 1'b0);
        chk("t6_rst_eng_addr", bus.eng_addr, 16'h0000);
        chk("t6_rst_f_rdata", bus.f_rdata, 8'h00);
        chk("t6_rst_f_rvalid", bus.f_rvalid, 1'b0);
        rst_n = 1'b1; m_busy = 1'b0;
        tick(1);
        m_done = 1'b1; m_data = 8'h77;
        tick(1);
        m_done = 1'b0;
        tick(2);
        chk("t6_stale_done_ignored", bus.f_rdata, 8'h00);
        eng_resp = 8'h3C; eng_auto = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = 16'h0201;
        wait_sig("t6_wait_ack2", 0, 5, n);
        chk("t6_addr2", bus.eng_addr, 16'h0201);
        bus.f_req = 1'b0;
        wait_sig("t6_wait_rvalid2", 2, 50, n);
        chk("t6_rdata2", bus.f_rdata, 8'h3C);
        chk("t6_err2", bus.f_err, 1'b0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
